y86_dmem_arbiter: RTL and testbench
===================================

Name: y86_dmem_arbiter

Overview:
- Shares the single-port Y86 data memory between two requesters: the fetch stage (F port, read-only) and the memory stage (M port, read/write, driven from icode/valE/valA).
- Sequences each access over a fixed-latency memory using a req/ready/valid handshake.
- Flags out-of-range addresses so the pipeline can raise the ADR status.
- Sits between the fetch/memory stages and the memory array.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; legal access needs addr+7 < MEM_BYTES with no 64-bit overflow.
- MEM_LAT, 2, cycles from mem_en to mem_rdata valid; must be >= 1.
- MAX_STREAK, 4, max consecutive M grants while F is pending before F is forced.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request; held until f_ready
- f_addr  in  64  fetch byte address
- f_ready  out  1  fetch request accepted this cycle
- f_valid  out  1  fetch response pulse
- f_rdata  out  64  fetch read data
- f_err  out  1  fetch address error, with f_valid
- m_req  in  1  memory-stage request; held until m_ready
- m_we  in  1  1 = write (rmmovq/pushq/call), 0 = read
- m_addr  in  64  memory-stage byte address (valE or valA)
- m_wdata  in  64  write data (valA or valP)
- m_ready  out  1  memory-stage request accepted
- m_valid  out  1  memory-stage response pulse; for writes it is the ack
- m_rdata  out  64  read data (valM); 0 on writes
- m_err  out  1  memory-stage address error, with m_valid
- mem_en  out  1  memory strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  64  memory byte address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (async, rst_n=0): state IDLE, all outputs 0, streak=0, latched regs 0. Reset mid-access abandons the access; no valid pulse follows.
- Ready: f_ready/m_ready are combinational, asserted only in IDLE, and at most one per cycle.
- Grant priority: M wins when both request.
  - Exception: F wins if f_req=1 and streak==MAX_STREAK.
  - streak increments on each M grant with f_req=1.
  - streak clears on an F grant, or on an M grant with f_req=0.
- Accept edge (req & ready sampled): latch addr, we (F forces we=0), wdata and owner. Next state: ISSUE if the address is legal, else RESP with err=1, rdata=0, no memory access.
- ISSUE: mem_en=1 with mem_we/mem_addr/mem_wdata from the latches. Load cnt=MEM_LAT, go to WAIT.
- WAIT: decrement cnt each cycle. On the edge where cnt==1, capture mem_rdata (reads only; writes capture 0), go to RESP.
- RESP: owner's valid=1 for exactly one cycle with rdata/err; return to IDLE.
- Legal-access latency from accept edge to valid: MEM_LAT+2 cycles. Illegal access: 1 cycle.
- Throughput: one access per MEM_LAT+3 cycles; a new grant is possible in the first IDLE cycle after RESP.
- Outside ISSUE, mem_en=0 and mem_addr/mem_wdata/mem_we hold their last values.
- rdata/err outputs are valid only while the matching valid is high; they hold their value until the next response.
- Inputs other than req are ignored outside the accept cycle. A req dropped before ready is simply not served.
- Address check: illegal if addr > MEM_BYTES-8 (unsigned 64-bit compare, which also covers wrap-around). Addr 0xFFFFFFFFFFFFFFF9 is illegal.
- No alignment requirement; the byte address is passed through unchanged.

Test Plan:
- M read alone: m_req=1, m_we=0, m_addr=0x10, mem returns 0x234567890 → m_ready at cycle 0, mem_en at cycle 1, m_valid at cycle 4 with m_rdata=0x234567890, m_err=0.
- M write: m_we=1, m_addr=0xA, m_wdata=0x427654A → mem_en=1, mem_we=1, mem_addr=0xA, mem_wdata=0x427654A for one cycle; m_valid pulse with m_rdata=0.
- Contention and fairness: f_req and m_req held high continuously, MAX_STREAK=4 → grant order M,M,M,M,F,M,…; f_ready never asserts in the same cycle as m_ready.
- Address error: m_addr=0x3F9 (MEM_BYTES=1024) → no mem_en, m_valid the cycle after accept with m_err=1, m_rdata=0. Also m_addr=0x3F8 → legal.
- Wrap-around: f_addr=0xFFFFFFFFFFFFFFFC → f_err=1, no mem_en.
- Reset mid-access: assert rst_n=0 during WAIT → all outputs 0 immediately; after release, no stale valid; the next request completes normally.

Source files
------------

// File: rtl/y86_dmem_arbiter.sv
// Arbitrates the single-port Y86 data memory between fetch (read-only) and memory stage (read/write).
// Latency: MEM_LAT+2 cycles accept-to-valid for legal addresses, 1 cycle for out-of-range ones.
// Backpressure: ready only in IDLE, one grant per cycle; M has priority unless F has waited MAX_STREAK grants.
module y86_dmem_arbiter #(
    parameter int MEM_BYTES  = 1024,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_ready,
    output logic        f_valid,
    output logic [63:0] f_rdata,
    output logic        f_err,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_ready,
    output logic        m_valid,
    output logic [63:0] m_rdata,
    output logic        m_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT);
    localparam logic [SW-1:0] STREAK_LIM = SW'(MAX_STREAK);
    // Highest legal start address; the unsigned compare also rejects wrapped addresses.
    localparam logic [63:0]   MAX_ADDR   = 64'(MEM_BYTES - 8);

    logic [1:0]    state;
    logic          owner_m;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;

    logic          idle;
    logic          force_f;
    logic          m_grant;
    logic          f_grant;
    logic [63:0]   acc_addr;
    logic          acc_legal;
    logic [63:0]   cap_data;

    assign idle      = (state == IDLE);
    assign force_f   = f_req && (streak == STREAK_LIM);
    assign m_grant   = idle && m_req && !force_f;
    assign f_grant   = idle && f_req && !m_grant;
    assign acc_addr  = m_grant ? m_addr : f_addr;
    assign acc_legal = (acc_addr <= MAX_ADDR);
    assign cap_data  = mem_we ? 64'd0 : mem_rdata;

    // Ready is masked during reset so every output reads 0 while rst_n is low.
    assign f_ready = rst_n && f_grant;
    assign m_ready = rst_n && m_grant;
    assign f_valid = (state == RESP) && !owner_m;
    assign m_valid = (state == RESP) && owner_m;
    assign mem_en  = (state == ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_m   <= 1'b0;
            cnt       <= '0;
            streak    <= '0;
            f_rdata   <= 64'd0;
            f_err     <= 1'b0;
            m_rdata   <= 64'd0;
            m_err     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_grant) begin
                        streak <= f_req ? streak + SW'(1) : '0;
                    end else if (f_grant) begin
                        streak <= '0;
                    end
                    if (m_grant || f_grant) begin
                        owner_m <= m_grant;
                        if (acc_legal) begin
                            mem_addr  <= acc_addr;
                            mem_we    <= m_grant && m_we;
                            mem_wdata <= m_grant ? m_wdata : 64'd0;
                            state     <= ISSUE;
                        end else begin
                            if (m_grant) begin
                                m_err   <= 1'b1;
                                m_rdata <= 64'd0;
                            end else begin
                                f_err   <= 1'b1;
                                f_rdata <= 64'd0;
                            end
                            state <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        if (owner_m) begin
                            m_rdata <= cap_data;
                            m_err   <= 1'b0;
                        end else begin
                            f_rdata <= cap_data;
                            f_err   <= 1'b0;
                        end
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_dmem_arbiter.sv
// Bench for y86_dmem_arbiter: directed scenarios then random traffic, checked cycle by cycle
// against a transaction-timing model (grant rule, response cycle numbers, memory contents function).
module tb_y86_dmem_arbiter;

    localparam int MEM_BYTES  = 1024;
    localparam int MEM_LAT    = 2;
    localparam int MAX_STREAK = 4;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_ready, f_valid, f_err;
    logic [63:0] f_addr, f_rdata;
    logic        m_req, m_we, m_ready, m_valid, m_err;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    y86_dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_valid(f_valid),
        .f_rdata(f_rdata), .f_err(f_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_valid(m_valid), .m_rdata(m_rdata), .m_err(m_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester-side shadow values, applied at each negedge by step()
    logic        tf_req = 0, tm_req = 0, tm_we = 0, keep_req = 0;
    logic [63:0] tf_addr = 0, tm_addr = 0, tm_wdata = 0;

    // reference model state: cycle numbers of expected events
    int          n = 0;
    int          next_free, f_vcyc, m_vcyc, issue_cyc, rd_due, streak;
    logic [63:0] f_exp_rd, m_exp_rd, iss_addr, iss_wdata, rd_data;
    logic        f_exp_err, m_exp_err, iss_we;

    function automatic logic [63:0] memfunc(input logic [63:0] a);
        return {a[31:0] ^ 32'h9E37_79B9, ~a[31:0]};
    endfunction

    function automatic logic [63:0] randaddr();
        case ($urandom_range(7))
            0:       return 64'h3F8;
            1:       return 64'h3F9;
            2:       return {$urandom, $urandom};
            3:       return 64'hFFFF_FFFF_FFFF_FFF9;
            default: return 64'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        next_free = 0; f_vcyc = -1; m_vcyc = -1; issue_cyc = -1; rd_due = -1; streak = 0;
        f_exp_rd = 0; m_exp_rd = 0; f_exp_err = 0; m_exp_err = 0;
        iss_addr = 0; iss_wdata = 0; iss_we = 0; rd_data = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_f_ready"}, f_ready, 0);
        chk({tag, "_m_ready"}, m_ready, 0);
        chk({tag, "_f_valid"}, f_valid, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_f_rdata"}, f_rdata, 0);
        chk({tag, "_m_rdata"}, m_rdata, 0);
        chk({tag, "_f_err"}, f_err, 0);
        chk({tag, "_m_err"}, m_err, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic step();
        logic idle_e, force_e, mg, fg, we, bad;
        logic [63:0] a, rd;
        int vc;
        @(negedge clk);
        f_req = tf_req; f_addr = tf_addr;
        m_req = tm_req; m_we = tm_we; m_addr = tm_addr; m_wdata = tm_wdata;
        #1;
        n++;
        idle_e  = (n >= next_free);
        force_e = f_req && (streak == MAX_STREAK);
        mg = idle_e && m_req && !force_e;
        fg = idle_e && f_req && !mg;
        chk("f_ready", f_ready, fg);
        chk("m_ready", m_ready, mg);
        chk("one_ready", f_ready & m_ready, 0);
        chk("f_valid", f_valid, n == f_vcyc);
        if (n == f_vcyc) begin
            chk("f_rdata", f_rdata, f_exp_rd);
            chk("f_err", f_err, f_exp_err);
        end
        chk("m_valid", m_valid, n == m_vcyc);
        if (n == m_vcyc) begin
            chk("m_rdata", m_rdata, m_exp_rd);
            chk("m_err", m_err, m_exp_err);
        end
        chk("mem_en", mem_en, n == issue_cyc);
        if (n == issue_cyc) begin
            chk("mem_addr", mem_addr, iss_addr);
            chk("mem_we", mem_we, iss_we);
            if (iss_we) chk("mem_wdata", mem_wdata, iss_wdata);
        end
        // memory returns data only on the cycle it is due; junk otherwise
        mem_rdata = (n == rd_due) ? rd_data : {$urandom, $urandom};
        if (mg || fg) begin
            a   = mg ? m_addr : f_addr;
            we  = mg && m_we;
            bad = (a > MAX_ADDR);
            if (bad) begin
                vc = n + 1; next_free = n + 2; rd = 0;
            end else begin
                issue_cyc = n + 1; iss_addr = a; iss_we = we; iss_wdata = m_wdata;
                rd_due = n + 1 + MEM_LAT; rd_data = memfunc(a);
                vc = n + MEM_LAT + 2; next_free = vc + 1;
                rd = we ? 64'd0 : memfunc(a);
            end
            if (mg) begin
                m_vcyc = vc; m_exp_rd = rd; m_exp_err = bad;
                streak = f_req ? streak + 1 : 0;
                if (keep_req) tm_addr = randaddr(); else tm_req = 0;
            end else begin
                f_vcyc = vc; f_exp_rd = rd; f_exp_err = bad;
                streak = 0;
                if (keep_req) tf_addr = randaddr(); else tf_req = 0;
            end
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        rst_n = 0; f_req = 0; f_addr = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        mem_rdata = 0;
        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // M read alone, then M write
        tm_req = 1; tm_we = 0; tm_addr = 64'h10; steps(6);
        tm_req = 1; tm_we = 1; tm_addr = 64'hA; tm_wdata = 64'h427654A; steps(6);
        // boundary addresses
        tm_req = 1; tm_we = 0; tm_addr = 64'h3F9; steps(3);
        tm_req = 1; tm_we = 0; tm_addr = 64'h3F8; steps(6);
        tf_req = 1; tf_addr = 64'hFFFF_FFFF_FFFF_FFFC; steps(3);
        tf_req = 1; tf_addr = 64'hFFFF_FFFF_FFFF_FFF9; steps(3);
        // contention: both requests held high
        keep_req = 1; tf_req = 1; tm_req = 1; tm_we = 0; tf_addr = 64'h40; tm_addr = 64'h80;
        steps(60);
        keep_req = 0; tf_req = 0; tm_req = 0; steps(8);

        // reset while the access is in WAIT
        tm_req = 1; tm_we = 0; tm_addr = 64'h20; steps(3);
        #2 rst_n = 0;
        #1 check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        steps(2);
        tm_req = 1; tm_we = 0; tm_addr = 64'h28; steps(6);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if (!tf_req) begin
                tf_addr = randaddr();
                if ($urandom_range(3) == 0) tf_req = 1;
            end else if ($urandom_range(15) == 0) tf_req = 0;
            if (!tm_req) begin
                tm_addr = randaddr(); tm_we = 1'($urandom_range(1)); tm_wdata = {$urandom, $urandom};
                if ($urandom_range(2) == 0) tm_req = 1;
            end else if ($urandom_range(15) == 0) tm_req = 0;
            step();
        end
        tf_req = 0; tm_req = 0; steps(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
